// File: rtl/axi_sub_pkg.sv
// Shared encodings for the AXI write subordinate: burst types, responses, FSM states.
package axi_sub_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DATA = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/axi_wr_subordinate_if.sv
// AXI write-channel bundle (AW, W, B) between a write master and the subordinate.
interface axi_wr_subordinate_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 3
);

  logic                      awvalid;
  logic                      awready;
  logic [ID_WIDTH-1:0]       awid;
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic [7:0]                awlen;
  logic [2:0]                awsize;
  logic [1:0]                awburst;

  logic                      wvalid;
  logic                      wready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      wlast;

  logic                      bvalid;
  logic                      bready;
  logic [ID_WIDTH-1:0]       bid;
  logic [1:0]                bresp;

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast,
    output bready,
    input  awready, wready, bvalid, bid, bresp
  );

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast,
    input  bready,
    output awready, wready, bvalid, bid, bresp
  );

endinterface

// File: rtl/axi_sync_fifo.sv
// Synchronous FIFO, registered storage, data visible at o_dat while not empty.
// Push is refused only when full with no simultaneous pop; pop of an empty FIFO is ignored.
module axi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_dat     = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_dat;
  end

endmodule

// File: rtl/axi_wr_subordinate.sv
// AXI write subordinate with early-write-data buffer and word memory; one outstanding write,
// AW-to-bvalid len+2 cycles with data buffered; W stalls only when the buffer is full.
module axi_wr_subordinate
  import axi_sub_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 3,
  parameter int WDEPTH     = 8,
  parameter int MEM_WORDS  = 16
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  axi_wr_subordinate_if.slave           s_axi,
  input  logic [$clog2(MEM_WORDS)-1:0]  dbg_idx,
  output logic [DATA_WIDTH-1:0]         dbg_data
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LG     = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int FW     = DATA_WIDTH + STRB_W + 1;
  localparam logic [2:0] MAX_SIZE = 3'(LG);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_wrap_mask;
  logic [7:0]            r_len;
  logic [7:0]            r_beat;
  logic [2:0]            r_size;
  burst_e                r_burst;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  logic                  w_awready;
  logic                  w_bvalid;
  logic                  w_aw_hs;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [FW-1:0]         w_fifo_in;
  logic [FW-1:0]         w_fifo_out;
  logic [DATA_WIDTH-1:0] w_bdata;
  logic [STRB_W-1:0]     w_bstrb;
  logic                  w_blast;
  logic                  w_last_beat;
  logic                  w_in_range;
  logic [ADDR_WIDTH-1:0] w_aw_mask;
  logic [ADDR_WIDTH-1:0] w_step;
  logic [ADDR_WIDTH-1:0] w_word;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [IDX_W-1:0]      w_widx;

  // W buffer: accepts data regardless of AW state, so masters may send data first.
  assign w_push    = s_axi.wvalid & s_axi.wready;
  assign w_fifo_in = {s_axi.wdata, s_axi.wstrb, s_axi.wlast};
  assign {w_bdata, w_bstrb, w_blast} = w_fifo_out;

  axi_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (WDEPTH)
  ) u_wbuf (
    .clk     (aclk),
    .rst_n   (aresetn),
    .i_push  (w_push),
    .i_dat   (w_fifo_in),
    .i_pop   (w_pop),
    .o_dat   (w_fifo_out),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign s_axi.wready  = aresetn & ~w_full;
  assign s_axi.awready = aresetn & w_awready;
  assign s_axi.bvalid  = w_bvalid;
  assign s_axi.bid     = r_id;
  assign s_axi.bresp   = r_err ? RESP_SLVERR : RESP_OKAY;
  assign w_aw_hs       = s_axi.awvalid & s_axi.awready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_awready   = 1'b0;
    w_bvalid    = 1'b0;
    w_pop       = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_awready = 1'b1;
        if (s_axi.awvalid) w_state_nxt = DATA;
      end
      DATA: begin
        w_pop = ~w_empty;
        if (!w_empty && w_last_beat) w_state_nxt = RESP;
      end
      RESP: begin
        w_bvalid = 1'b1;
        if (s_axi.bready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Wrap region is (len+1) transfers of 2^size bytes, aligned to its own size.
  assign w_aw_mask   = ((ADDR_WIDTH'(s_axi.awlen) + ADDR_WIDTH'(1)) << s_axi.awsize) - ADDR_WIDTH'(1);
  assign w_step      = ADDR_WIDTH'(1) << r_size;
  assign w_word      = r_addr >> LG;
  assign w_in_range  = (w_word < ADDR_WIDTH'(MEM_WORDS));
  assign w_widx      = w_word[IDX_W-1:0];
  assign w_last_beat = (r_beat == r_len);

  always_comb begin
    w_addr_nxt = r_addr + w_step;
    case (r_burst)
      BURST_FIXED: w_addr_nxt = r_addr;
      BURST_WRAP:  w_addr_nxt = (r_addr & ~r_wrap_mask) | ((r_addr + w_step) & r_wrap_mask);
      default:     w_addr_nxt = r_addr + w_step;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_id        <= '0;
      r_addr      <= '0;
      r_wrap_mask <= '0;
      r_len       <= '0;
      r_beat      <= '0;
      r_size      <= '0;
      r_burst     <= BURST_INCR;
      r_err       <= 1'b0;
    end else if (w_aw_hs) begin
      r_id        <= s_axi.awid;
      r_addr      <= s_axi.awaddr;
      r_wrap_mask <= w_aw_mask;
      r_len       <= s_axi.awlen;
      r_beat      <= '0;
      r_size      <= s_axi.awsize;
      r_burst     <= burst_e'(s_axi.awburst);
      r_err       <= (s_axi.awsize > MAX_SIZE) || (s_axi.awburst == BURST_RSVD);
    end else if (w_pop) begin
      r_addr <= w_addr_nxt;
      r_beat <= r_beat + 8'd1;
      // The beat count still ends the burst; a misplaced wlast only poisons the response.
      if (!w_in_range || (w_blast != w_last_beat)) r_err <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (w_pop && w_in_range) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_bstrb[b]) r_mem[w_widx][8*b +: 8] <= w_bdata[8*b +: 8];
      end
    end
  end

  assign dbg_data = r_mem[dbg_idx];

endmodule

// File: tb/tb_axi_wr_subordinate.sv
// Randomized and directed bench for axi_wr_subordinate against a transaction-level memory model.
module tb_axi_wr_subordinate;
  import axi_sub_pkg::*;

  localparam int AW = 32, DW = 64, IW = 3, WD = 8, MW = 16;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [3:0]  dbg_idx;
  logic [63:0] dbg_data;

  always #5 aclk = ~aclk;

  axi_wr_subordinate_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  axi_wr_subordinate #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .WDEPTH(WD), .MEM_WORDS(MW)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .s_axi    (bus),
    .dbg_idx  (dbg_idx),
    .dbg_data (dbg_data)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] mdl_mem [MW];
  logic [63:0] bd [64];
  logic [7:0]  bs [64];
  logic        bl [64];

  // Reference: walk the burst byte address with AXI arithmetic and merge strobed bytes.
  function automatic logic [1:0] model_burst(input longint unsigned addr, input int len,
                                             input int size, input int burst, input int off);
    bit err;
    longint unsigned a, step, region, base;
    longint unsigned word;
    err    = (size > 3) || (burst == 3);
    a      = addr;
    step   = 64'd1 << size;
    region = longint'(len + 1) * step;
    base   = (a / region) * region;
    for (int i = 0; i <= len; i++) begin
      word = a / 8;
      if (word >= MW) err = 1'b1;
      else for (int b = 0; b < 8; b++)
        if (bs[off+i][b]) mdl_mem[word][8*b +: 8] = bd[off+i][8*b +: 8];
      if (bl[off+i] != (i == len)) err = 1'b1;
      if (burst == 0)      a = a;
      else if (burst == 2) a = base + ((a + step - base) % region);
      else                 a = a + step;
    end
    return err ? 2'b10 : 2'b00;
  endfunction

  task automatic push_w(input logic [63:0] d, input logic [7:0] s, input logic l);
    bit hs = 1'b0;
    bus.wvalid = 1'b1; bus.wdata = d; bus.wstrb = s; bus.wlast = l;
    for (int t = 0; t < 300 && !hs; t++) begin
      @(negedge aclk); hs = bus.wready;
      @(posedge aclk); #1;
    end
    bus.wvalid = 1'b0;
    checks++;
    if (!hs) begin errors++; $display("FAIL w_handshake: wready observed 0 for 300 cycles, required 1"); end
  endtask

  task automatic send_beats(input int off, input int n);
    for (int i = 0; i < n; i++) push_w(bd[off+i], bs[off+i], bl[off+i]);
  endtask

  task automatic do_aw(input logic [2:0] id, input logic [31:0] addr, input int len,
                       input int size, input int burst);
    bit hs = 1'b0;
    bus.awvalid = 1'b1; bus.awid = id; bus.awaddr = addr;
    bus.awlen = 8'(len); bus.awsize = 3'(size); bus.awburst = 2'(burst);
    for (int t = 0; t < 300 && !hs; t++) begin
      @(negedge aclk); hs = bus.awready;
      @(posedge aclk); #1;
    end
    bus.awvalid = 1'b0;
    checks++;
    if (!hs) begin errors++; $display("FAIL aw_handshake: awready observed 0 for 300 cycles, required 1"); end
  endtask

  // lat >= 0: cycles from the AW edge to bvalid, which is len+1 edges (len+2 cycles incl. AW).
  task automatic wait_b(input logic [2:0] eid, input logic [1:0] eresp, input int lat);
    int cnt = 0;
    bit seen = 1'b0;
    int hold;
    while (!seen && cnt < 300) begin
      @(negedge aclk);
      if (bus.bvalid) seen = 1'b1; else cnt++;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL b_timeout: bvalid observed 0 for 300 cycles, required 1");
      @(posedge aclk); #1;
      return;
    end
    if (lat >= 0) begin
      checks++;
      if (cnt != lat) begin errors++; $display("FAIL b_latency: got %0d edges, required %0d", cnt, lat); end
    end
    hold = $urandom_range(0, 3);
    for (int h = 0; h < hold; h++) begin
      @(negedge aclk);
      checks++;
      if (bus.bvalid !== 1'b1 || bus.bid !== eid) begin
        errors++; $display("FAIL b_hold: bvalid=%b bid=%0d, required 1 and %0d", bus.bvalid, bus.bid, eid);
      end
    end
    checks++;
    if (bus.bid !== eid) begin errors++; $display("FAIL bid: got %0d, required %0d", bus.bid, eid); end
    checks++;
    if (bus.bresp !== eresp) begin errors++; $display("FAIL bresp: got %0d, required %0d", bus.bresp, eresp); end
    bus.bready = 1'b1;
    @(posedge aclk); #1;
    bus.bready = 1'b0;
    checks++;
    if (bus.bvalid !== 1'b0) begin errors++; $display("FAIL b_drop: bvalid=%b after handshake, required 0", bus.bvalid); end
  endtask

  task automatic check_mem(input string tag);
    for (int w = 0; w < MW; w++) begin
      dbg_idx = 4'(w);
      #1;
      checks++;
      if (dbg_data !== mdl_mem[w]) begin
        errors++; $display("FAIL mem_%s[%0d]: got %h, required %h", tag, w, dbg_data, mdl_mem[w]);
      end
    end
    @(posedge aclk); #1;
  endtask

  task automatic run_burst(input logic [2:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst, input bit prebuf);
    logic [1:0] eresp;
    eresp = model_burst(addr, len, size, burst, 0);
    if (prebuf) begin
      send_beats(0, len + 1);
      do_aw(id, addr, len, size, burst);
      wait_b(id, eresp, len + 1);
    end else begin
      fork
        send_beats(0, len + 1);
        do_aw(id, addr, len, size, burst);
      join
      wait_b(id, eresp, -1);
    end
  endtask

  task automatic fill(input int n, input logic [7:0] strb);
    for (int i = 0; i < n; i++) begin
      bd[i] = {$urandom, $urandom};
      bs[i] = strb;
      bl[i] = (i == n - 1);
    end
  endtask

  task automatic release_reset;
    @(negedge aclk); aresetn = 1'b1;
    @(posedge aclk); #1;
  endtask

  task automatic test_reset;
    #2;
    checks += 5;
    if (bus.awready !== 1'b0) begin errors++; $display("FAIL rst_awready: got %b, required 0", bus.awready); end
    if (bus.wready  !== 1'b0) begin errors++; $display("FAIL rst_wready: got %b, required 0", bus.wready); end
    if (bus.bvalid  !== 1'b0) begin errors++; $display("FAIL rst_bvalid: got %b, required 0", bus.bvalid); end
    if (bus.bid     !== 3'd0) begin errors++; $display("FAIL rst_bid: got %0d, required 0", bus.bid); end
    if (bus.bresp   !== 2'd0) begin errors++; $display("FAIL rst_bresp: got %0d, required 0", bus.bresp); end
    release_reset();
    checks += 2;
    if (bus.awready !== 1'b1) begin errors++; $display("FAIL idle_awready: got %b, required 1", bus.awready); end
    if (bus.wready  !== 1'b1) begin errors++; $display("FAIL idle_wready: got %b, required 1", bus.wready); end
  endtask

  task automatic test_init;
    fill(16, 8'hFF);
    run_burst(3'd1, 32'h0, 15, 3, 1, 1'b0);
    check_mem("init");
  endtask

  task automatic test_early_data;
    fill(4, 8'hFF);
    run_burst(3'd5, 32'h0, 3, 3, 1, 1'b1);
    check_mem("early");
  endtask

  task automatic test_wrap;
    logic [63:0] old [MW];
    logic [1:0]  eresp;
    int          ord [4] = '{3, 0, 1, 2};
    old = mdl_mem;
    fill(4, 8'hFF);
    eresp = model_burst(64'h18, 3, 3, 2, 0);
    send_beats(0, 4);
    do_aw(3'd2, 32'h18, 3, 3, 2);
    for (int k = 0; k < 4; k++) begin
      @(posedge aclk); #1;
      dbg_idx = 4'(ord[k]); #1;
      checks++;
      if (dbg_data !== bd[k]) begin errors++; $display("FAIL wrap_order beat%0d word%0d: got %h, required %h", k, ord[k], dbg_data, bd[k]); end
      if (k < 3) begin
        dbg_idx = 4'(ord[k+1]); #1;
        checks++;
        if (dbg_data !== old[ord[k+1]]) begin errors++; $display("FAIL wrap_early word%0d: got %h, required %h", ord[k+1], dbg_data, old[ord[k+1]]); end
      end
    end
    wait_b(3'd2, eresp, -1);
    check_mem("wrap");
  endtask

  task automatic test_strobe;
    bd[0] = '1; bs[0] = 8'hFF; bl[0] = 1'b1;
    run_burst(3'd3, 32'h0, 0, 3, 1, 1'b1);
    bd[0] = '0; bs[0] = 8'h0F; bl[0] = 1'b1;
    run_burst(3'd3, 32'h0, 0, 3, 1, 1'b1);
    dbg_idx = 4'd0; #1;
    checks++;
    if (dbg_data !== 64'hFFFF_FFFF_0000_0000) begin
      errors++; $display("FAIL strobe_merge: got %h, required ffffffff00000000", dbg_data);
    end
    check_mem("strobe");
  endtask

  task automatic test_errors;
    fill(2, 8'hFF); bl[0] = 1'b1;
    run_burst(3'd4, 32'h20, 1, 3, 1, 1'b1);
    fill(1, 8'hFF);
    run_burst(3'd6, 32'h80, 0, 3, 1, 1'b1);
    fill(2, 8'hFF);
    run_burst(3'd0, 32'h40, 1, 4, 1, 1'b1);
    fill(2, 8'h3C);
    run_burst(3'd7, 32'h30, 1, 3, 3, 1'b1);
    check_mem("errors");
  endtask

  task automatic test_back_to_back;
    logic [1:0] ea, eb;
    fill(5, 8'hFF); bl[1] = 1'b1; bl[0] = 1'b0;
    ea = model_burst(64'h48, 1, 3, 1, 0);
    eb = model_burst(64'h10, 2, 3, 0, 2);
    send_beats(0, 5);
    do_aw(3'd1, 32'h48, 1, 3, 1);
    wait_b(3'd1, ea, 2);
    do_aw(3'd2, 32'h10, 2, 3, 0);
    wait_b(3'd2, eb, 3);
    check_mem("b2b");
  endtask

  task automatic test_random;
    int len, size, burst, region, flip;
    logic [31:0] addr;
    for (int it = 0; it < 20; it++) begin
      size  = ($urandom_range(0, 3) == 0) ? 2 : 3;
      burst = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      if (burst == 2) begin
        len    = (1 << $urandom_range(1, 3)) - 1;
        region = (len + 1) << size;
        addr   = 32'($urandom_range(0, 128 / region - 1) * region + ($urandom_range(0, len) << size));
      end else begin
        len  = $urandom_range(0, 7);
        addr = 32'($urandom_range(0, 15) * 8 + ((size == 2) ? 4 * $urandom_range(0, 1) : 0));
        if ($urandom_range(0, 7) == 0) addr = addr + 32'h80;
      end
      fill(len + 1, 8'h00);
      for (int i = 0; i <= len; i++) bs[i] = 8'($urandom);
      flip = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len) : -1;
      if (flip >= 0) bl[flip] = ~bl[flip];
      run_burst(3'($urandom), addr, len, size, burst, 1'($urandom));
      check_mem("rand");
    end
  endtask

  task automatic test_reset_mid;
    fill(2, 8'hFF);
    void'(model_burst(64'h78, 1, 3, 1, 0));
    send_beats(0, 2);
    do_aw(3'd7, 32'h78, 1, 3, 1);
    for (int t = 0; t < 50 && bus.bvalid !== 1'b1; t++) @(negedge aclk);
    checks++;
    if (bus.bvalid !== 1'b1) begin errors++; $display("FAIL mid_bvalid: got %b, required 1", bus.bvalid); end
    aresetn = 1'b0; #1;
    checks += 3;
    if (bus.bvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_bvalid: got %b, required 0", bus.bvalid); end
    if (bus.bid    !== 3'd0) begin errors++; $display("FAIL mid_rst_bid: got %0d, required 0", bus.bid); end
    if (bus.bresp  !== 2'd0) begin errors++; $display("FAIL mid_rst_bresp: got %0d, required 0", bus.bresp); end
    release_reset();
    check_mem("after_rst");
  endtask

  task automatic test_full_reset;
    fill(8, 8'hFF);
    send_beats(0, 8);
    bus.wvalid = 1'b1; bus.wdata = '1; bus.wstrb = 8'hFF; bus.wlast = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge aclk);
      checks += 2;
      if (bus.wready  !== 1'b0) begin errors++; $display("FAIL full_wready: got %b, required 0", bus.wready); end
      if (bus.awready !== 1'b1) begin errors++; $display("FAIL full_awready: got %b, required 1", bus.awready); end
    end
    aresetn = 1'b0; #1;
    bus.wvalid = 1'b0;
    checks += 3;
    if (bus.bvalid  !== 1'b0) begin errors++; $display("FAIL full_rst_bvalid: got %b, required 0", bus.bvalid); end
    if (bus.wready  !== 1'b0) begin errors++; $display("FAIL full_rst_wready: got %b, required 0", bus.wready); end
    if (bus.awready !== 1'b0) begin errors++; $display("FAIL full_rst_awready: got %b, required 0", bus.awready); end
    release_reset();
    checks++;
    if (bus.wready !== 1'b1) begin errors++; $display("FAIL empty_wready: got %b, required 1", bus.wready); end
    // An empty buffer must leave the new burst waiting for data.
    do_aw(3'd3, 32'h8, 0, 3, 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      checks++;
      if (bus.bvalid !== 1'b0) begin errors++; $display("FAIL empty_stall: bvalid=%b at cycle %0d, required 0", bus.bvalid, c); end
    end
    @(posedge aclk); #1;
    fill(1, 8'hF0);
    send_beats(0, 1);
    wait_b(3'd3, model_burst(64'h8, 0, 3, 1, 0), -1);
    check_mem("full_rst");
  endtask

  initial begin
    bus.awvalid = 1'b0; bus.awid = '0; bus.awaddr = '0; bus.awlen = '0;
    bus.awsize = '0; bus.awburst = '0; bus.wvalid = 1'b0; bus.wdata = '0;
    bus.wstrb = '0; bus.wlast = 1'b0; bus.bready = 1'b0; dbg_idx = '0;
    test_reset();
    test_init();
    test_early_data();
    test_wrap();
    test_strobe();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_full_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
